pausible_port_rx: RTL

PAUSIBLE_PORT_RX -- requirements
Module: pausible_port_rx

---
 rtl/pausible_port_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pausible_port_rx.sv
// Receive port for a pausible-clock domain: a 4-phase bundled-data word is captured
// while the clock is paused, then moved through a holding register into a FIFO.
module pausible_port_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    rstn,
    input  logic                    in_req,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ack,
    output logic                    pc_req,
    input  logic                    pc_grant,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {PS_IDLE, PS_REQ, PS_ACK, PS_RTZ} port_state_e;

    port_state_e           port_state;
    logic                  ack_clr_n;
    logic                  ack_phase_q, ack_phase_d;
    logic                  cap_toggle_q, cap_toggle_d;
    logic [DATA_WIDTH-1:0] hr_q, hr_d;

    logic                  seen_toggle_q, seen_toggle_d;
    logic                  hr_full_q, hr_full_d;
    logic                  run_q, run_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    logic                  hr_pending;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;

    // The handshake phase ends only once the sender has returned to zero and the mutex has let go.
    assign ack_clr_n = rstn & (in_req | pc_grant);

    always_comb begin
        ack_phase_d  = 1'b1;
        cap_toggle_d = ~cap_toggle_q;
        hr_d         = in_data;
    end

    always_ff @(posedge pc_grant or negedge ack_clr_n) begin
        if (!ack_clr_n) begin
            ack_phase_q <= 1'b0;
        end else begin
            ack_phase_q <= ack_phase_d;
        end
    end

    always_ff @(posedge pc_grant or negedge rstn) begin
        if (!rstn) begin
            cap_toggle_q <= 1'b0;
            hr_q         <= '0;
        end else begin
            cap_toggle_q <= cap_toggle_d;
            hr_q         <= hr_d;
        end
    end

    always_comb begin
        port_state = PS_IDLE;
        if (ack_phase_q) begin
            port_state = in_req ? PS_ACK : PS_RTZ;
        end else if (in_req) begin
            port_state = PS_REQ;
        end
    end

    // A capture not yet seen by the clock domain also blocks a new request, so HR is never overwritten.
    assign hr_pending = cap_toggle_q ^ seen_toggle_q;
    assign in_ack     = (port_state == PS_ACK) || (port_state == PS_RTZ);
    assign pc_req     = (port_state == PS_REQ) && run_q && !hr_full_q && !hr_pending;

    assign fifo_full  = (count_q == FULL_COUNT);
    assign out_valid  = (count_q != '0);
    assign pop        = out_valid && out_ready;
    assign push       = hr_full_q && (!fifo_full || pop);
    assign out_data   = mem_q[rd_ptr_q];
    assign count      = count_q;

    always_comb begin
        run_d         = 1'b1;
        seen_toggle_d = cap_toggle_q;
        hr_full_d     = (hr_full_q && !push) || hr_pending;
        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        mem_d         = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = hr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            run_q         <= 1'b0;
            seen_toggle_q <= 1'b0;
            hr_full_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            run_q         <= run_d;
            seen_toggle_q <= seen_toggle_d;
            hr_full_q     <= hr_full_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            mem_q         <= mem_d;
        end
    end

endmodule
